// File: rtl/path_delay_meter.sv
// Cycle-accurate launch-to-arrival delay monitor for a non-inverting path.
// Measures rise and fall delays separately and keeps running min/max statistics.
module path_delay_meter #(
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             src,
  input  logic             dst,
  output logic             valid,
  output logic [CNT_W-1:0] delay,
  output logic             rise,
  output logic             timeout,
  output logic             overlap,
  output logic             glitch,
  output logic             busy,
  output logic [CNT_W-1:0] min_rise,
  output logic [CNT_W-1:0] max_rise,
  output logic [CNT_W-1:0] min_fall,
  output logic [CNT_W-1:0] max_fall
);

  typedef enum logic [1:0] {IDLE, WAIT_LAUNCH, WAIT_ARRIVE} state_t;

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  function automatic logic [CNT_W-1:0] umin(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  function automatic logic [CNT_W-1:0] umax(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             exp_r, exp_n;
  logic             pol_r, pol_n;
  logic             src_q, dst_q;
  logic             src_e, dst_e;
  logic             res, ovl, glt, tmo;
  logic [CNT_W-1:0] res_d;
  logic [CNT_W-1:0] min_r_c, max_r_c, min_f_c, max_f_c;

  assign src_e = src ^ src_q;
  assign dst_e = dst ^ dst_q;

  // Stage 0: edge detect, next-state and result decode
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    exp_n   = exp_r;
    pol_n   = pol_r;
    res     = 1'b0;
    res_d   = cnt;
    ovl     = 1'b0;
    glt     = 1'b0;
    tmo     = 1'b0;
    if (!en) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE: state_n = WAIT_LAUNCH;
        WAIT_LAUNCH, WAIT_ARRIVE: begin
          if (src_e) begin
            // A new launch always wins; in WAIT_ARRIVE it discards the old one.
            ovl   = (state == WAIT_ARRIVE);
            exp_n = src;
            pol_n = src;
            if (dst_e && (dst == src)) begin
              res     = 1'b1;
              res_d   = '0;
              state_n = WAIT_LAUNCH;
            end else begin
              cnt_n   = CNT_W'(1);
              state_n = WAIT_ARRIVE;
            end
          end else if (state == WAIT_ARRIVE) begin
            if (dst_e && (dst == exp_r)) begin
              res     = 1'b1;
              state_n = WAIT_LAUNCH;
            end else if (dst_e) begin
              glt   = 1'b1;
              cnt_n = cnt + CNT_W'(1);
            end else if (cnt >= TMO) begin
              // >= also catches a glitch that stepped past the limit.
              tmo     = 1'b1;
              state_n = WAIT_LAUNCH;
            end else begin
              cnt_n = cnt + CNT_W'(1);
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Clear first, then fold in a coincident result.
  always_comb begin
    min_r_c = clr ? '1 : min_rise;
    max_r_c = clr ? '0 : max_rise;
    min_f_c = clr ? '1 : min_fall;
    max_f_c = clr ? '0 : max_fall;
  end

  // Stage 1: registered state, results and statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      exp_r    <= 1'b0;
      pol_r    <= 1'b0;
      src_q    <= 1'b0;
      dst_q    <= 1'b0;
      valid    <= 1'b0;
      delay    <= '0;
      rise     <= 1'b0;
      timeout  <= 1'b0;
      overlap  <= 1'b0;
      glitch   <= 1'b0;
      busy     <= 1'b0;
      min_rise <= '1;
      max_rise <= '0;
      min_fall <= '1;
      max_fall <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      exp_r   <= exp_n;
      pol_r   <= pol_n;
      src_q   <= src;
      dst_q   <= dst;
      valid   <= res;
      timeout <= tmo;
      overlap <= ovl;
      glitch  <= glt;
      busy    <= (state_n == WAIT_ARRIVE);
      if (res) begin
        delay <= res_d;
        rise  <= pol_n;
      end
      if (res && pol_n) begin
        min_rise <= umin(min_r_c, res_d);
        max_rise <= umax(max_r_c, res_d);
      end else begin
        min_rise <= min_r_c;
        max_rise <= max_r_c;
      end
      if (res && !pol_n) begin
        min_fall <= umin(min_f_c, res_d);
        max_fall <= umax(max_f_c, res_d);
      end else begin
        min_fall <= min_f_c;
        max_fall <= max_f_c;
      end
    end
  end

endmodule

// File: tb/tb_path_delay_meter.sv
// Directed bench for path_delay_meter: rise/fall delays, zero delay, timeout,
// glitch, overlap, clear and enable behaviour.
module tb_path_delay_meter;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst, en, clr, src, dst;
  logic             valid, rise, timeout, overlap, glitch, busy;
  logic [CNT_W-1:0] delay, min_rise, max_rise, min_fall, max_fall;

  int checks = 0;
  int errors = 0;

  path_delay_meter #(.CNT_W(CNT_W), .TIMEOUT(200)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .src(src), .dst(dst),
    .valid(valid), .delay(delay), .rise(rise), .timeout(timeout),
    .overlap(overlap), .glitch(glitch), .busy(busy),
    .min_rise(min_rise), .max_rise(max_rise),
    .min_fall(min_fall), .max_fall(max_fall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, got, want);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  int  n;
  logic vseen;

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; src = 1'b0; dst = 1'b0;
    step();
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_delay", delay, 0);
    check("rst_min_rise", min_rise, 255);
    check("rst_max_fall", max_fall, 0);
    rst = 1'b0;
    en  = 1'b1;
    step();
    // Reset in the middle of a measurement
    src = 1'b1;
    step();
    check("busy_launch", busy, 1);
    step(2);
    #3 rst = 1'b1;
    #1;
    check("async_busy", busy, 0);
    check("async_pulses", {valid, timeout, overlap, glitch}, 0);
    check("async_min_fall", min_fall, 255);
    src = 1'b0; en = 1'b0;
    step();
    rst = 1'b0;
    step();
    en = 1'b1;
    step(2);
    check("en_no_pulse", {valid, timeout, overlap, glitch, busy}, 0);

    // Rise delay 5
    src = 1'b1;
    step(5);
    dst = 1'b1;
    step();
    check("r5_valid", valid, 1);
    check("r5_delay", delay, 5);
    check("r5_rise", rise, 1);
    check("r5_min", min_rise, 5);
    check("r5_max", max_rise, 5);
    check("r5_busy", busy, 0);

    // Fall delay 7
    src = 1'b0;
    step();
    check("f7_valid_pulse", valid, 0);
    step(6);
    dst = 1'b0;
    step();
    check("f7_delay", {valid, rise, delay}, {1'b1, 1'b0, 8'd7});
    check("f7_min", min_fall, 7);
    check("f7_max", max_fall, 7);
    check("f7_min_rise_kept", min_rise, 5);

    // Clear, zero-delay rise, zero-delay fall, rise delay 3
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_stats", {min_rise, max_rise, min_fall, max_fall}, {8'hff, 8'h00, 8'hff, 8'h00});
    src = 1'b1; dst = 1'b1;
    step();
    check("z_rise", {valid, rise, delay}, {1'b1, 1'b1, 8'd0});
    src = 1'b0; dst = 1'b0;
    step();
    check("z_fall", {valid, rise, delay}, {1'b1, 1'b0, 8'd0});
    src = 1'b1;
    step(3);
    dst = 1'b1;
    step();
    check("r3_delay", {valid, delay}, {1'b1, 8'd3});
    check("r3_stats", {min_rise, max_rise}, {8'd0, 8'd3});
    src = 1'b0; dst = 1'b0;
    step();
    check("z_fall2", {valid, delay}, {1'b1, 8'd0});

    // Timeout on a rise launch
    src = 1'b1;
    n = 0; vseen = 1'b0;
    while (!timeout && n < 300) begin
      step();
      n++;
      if (valid) vseen = 1'b1;
    end
    check("tmo_cycles", n, 201);
    check("tmo_no_valid", vseen, 0);
    step();
    check("tmo_pulse_len", {timeout, busy}, 0);
    // dst moving in WAIT_LAUNCH without a launch is not a result
    dst = 1'b1;
    step();
    check("wl_dst_ignored", valid, 0);
    src = 1'b0;
    step(4);
    dst = 1'b0;
    step();
    check("post_tmo", {valid, rise, delay}, {1'b1, 1'b0, 8'd4});

    // Glitch during a rise measurement
    dst = 1'b1;
    step();
    src = 1'b1;
    step(2);
    dst = 1'b0;
    step();
    check("glitch_pulse", glitch, 1);
    step();
    check("glitch_len", glitch, 0);
    step(2);
    dst = 1'b1;
    step();
    check("glitch_delay", {valid, rise, delay}, {1'b1, 1'b1, 8'd6});

    // Overlap: two launches 3 cycles apart, arrival 4 after the second
    dst = 1'b0;
    step();
    src = 1'b0;
    step(3);
    src = 1'b1;
    step();
    check("ovl_pulse", {overlap, valid}, {1'b1, 1'b0});
    step(3);
    dst = 1'b1;
    step();
    check("ovl_delay", {valid, rise, delay, overlap}, {1'b1, 1'b1, 8'd4, 1'b0});

    // Clear coincident with a delay-9 fall result
    src = 1'b0;
    step(9);
    dst = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr9_delay", {valid, delay}, {1'b1, 8'd9});
    check("clr9_fall", {min_fall, max_fall}, {8'd9, 8'd9});
    check("clr9_rise", {min_rise, max_rise}, {8'hff, 8'h00});

    // Drop enable mid-flight
    src = 1'b1;
    step(3);
    check("en_busy", busy, 1);
    en = 1'b0;
    step();
    check("en_drop_busy", busy, 0);
    dst = 1'b1;
    step();
    check("en_drop_valid", {valid, timeout, overlap, glitch}, 0);
    check("en_delay_kept", delay, 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
